// File: rtl/alu_arbiter_if.sv
// Request/response and shared-ALU signal bundle for alu_arbiter.
// slave = arbiter side, master = requesters plus the shared ALU.
interface alu_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic              req1_valid;
  logic              req0_ready;
  logic              req1_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [3:0]        req0_op;
  logic [3:0]        req1_op;
  logic              rsp0_valid;
  logic              rsp1_valid;
  logic              rsp0_ready;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;
  logic [DATA_W-1:0] alu_in1;
  logic [DATA_W-1:0] alu_in2;
  logic [3:0]        alu_ctrl;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
           req0_op, req1_op, rsp0_ready, rsp1_ready, alu_result, alu_zero,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result,
           rsp_zero, alu_in1, alu_in2, alu_ctrl
  );

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
           req0_op, req1_op, rsp0_ready, rsp1_ready, alu_result, alu_zero,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result,
           rsp_zero, alu_in1, alu_in2, alu_ctrl
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing one combinational ALU (IDLE -> EXEC -> RESP).
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority to requester 0; default is round-robin.
module alu_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state;
  logic              owner;
  logic              grant1;
  logic              hs;
  logic              owner_rsp_ready;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [3:0]        sel_op;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic last_grant;
  // On contention, requester 1 wins only if requester 0 was granted last.
  assign grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
`else
  assign grant1 = bus.req1_valid && !bus.req0_valid;
`endif

  assign bus.req0_ready  = (state == IDLE) && bus.req0_valid && !grant1;
  assign bus.req1_ready  = (state == IDLE) && grant1;
  assign hs              = bus.req0_ready || bus.req1_ready;
  assign sel_a           = grant1 ? bus.req1_a  : bus.req0_a;
  assign sel_b           = grant1 ? bus.req1_b  : bus.req0_b;
  assign sel_op          = grant1 ? bus.req1_op : bus.req0_op;
  assign owner_rsp_ready = owner ? bus.rsp1_ready : bus.rsp0_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      owner          <= 1'b0;
      bus.rsp0_valid <= 1'b0;
      bus.rsp1_valid <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_zero   <= 1'b0;
      bus.alu_in1    <= '0;
      bus.alu_in2    <= '0;
      bus.alu_ctrl   <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant     <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            bus.alu_in1  <= sel_a;
            bus.alu_in2  <= sel_b;
            bus.alu_ctrl <= sel_op;
            owner        <= grant1;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant   <= grant1;
`endif
            state        <= EXEC;
          end
        end
        EXEC: begin
          bus.rsp_result <= bus.alu_result;
          bus.rsp_zero   <= bus.alu_zero;
          if (owner) bus.rsp1_valid <= 1'b1;
          else       bus.rsp0_valid <= 1'b1;
          state          <= RESP;
        end
        RESP: begin
          // Only the owner's ready releases the held result.
          if (owner_rsp_ready) begin
            bus.rsp0_valid <= 1'b0;
            bus.rsp1_valid <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed requests, queued expectations, response monitor.
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  typedef struct {
    int          id;
    logic [31:0] res;
    logic        z;
  } exp_t;
  exp_t q[$];

  alu_arbiter_if #(.DATA_W(32)) bus ();

  alu_arbiter #(.DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Shared combinational ALU model
  always_comb begin
    bus.alu_result = 32'h0;
    case (bus.alu_ctrl)
      4'b0000: bus.alu_result = bus.alu_in1 & bus.alu_in2;
      4'b0001: bus.alu_result = bus.alu_in1 | bus.alu_in2;
      4'b0010: bus.alu_result = bus.alu_in1 + bus.alu_in2;
      4'b0110: bus.alu_result = bus.alu_in1 - bus.alu_in2;
      4'b0101: bus.alu_result = (bus.alu_in2 == 0) ? 32'hFFFF_FFFF : bus.alu_in1 / bus.alu_in2;
      default: bus.alu_result = 32'h0;
    endcase
    bus.alu_zero = (bus.alu_result == 32'h0);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic pop_check(input int id);
    exp_t e;
    if (q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_rsp: got response for req%0d expected none at %0t", id, $time);
    end else begin
      e = q.pop_front();
      check("rsp_id", id, e.id);
      check("rsp_result", bus.rsp_result, e.res);
      check("rsp_zero", {31'h0, bus.rsp_zero}, {31'h0, e.z});
    end
  endtask

  // Monitor: consumes every accepted response against the queue head
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rsp0_valid && bus.rsp1_valid) begin
        n_cmp++;
        n_err++;
        $display("FAIL rsp_exclusive: got both rsp valids high expected one at %0t", $time);
      end
      if (bus.rsp0_valid && bus.rsp0_ready) pop_check(0);
      if (bus.rsp1_valid && bus.rsp1_ready) pop_check(1);
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic issue(input int r, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic [31:0] er, input logic ez,
                       input bit expect_rsp, input bit chk_lat);
    bit got = 1'b0;
    if (r == 0) begin
      bus.req0_a = a; bus.req0_b = b; bus.req0_op = op; bus.req0_valid = 1'b1;
    end else begin
      bus.req1_a = a; bus.req1_b = b; bus.req1_op = op; bus.req1_valid = 1'b1;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if ((r == 0 && bus.req0_ready) || (r == 1 && bus.req1_ready)) got = 1'b1;
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL issue_timeout: got no ready for req%0d expected ready within 20 cycles", r);
    end else if (expect_rsp) begin
      q.push_back('{id: r, res: er, z: ez});
    end
    @(posedge clk);
    #1;
    if (r == 0) bus.req0_valid = 1'b0;
    else        bus.req1_valid = 1'b0;
    if (chk_lat && got) begin
      @(negedge clk);
      check("latency_T+1", (r == 0) ? bus.rsp0_valid : bus.rsp1_valid, 0);
      @(negedge clk);
      check("latency_T+2", (r == 0) ? bus.rsp0_valid : bus.rsp1_valid, 1);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && (q.size() != 0 || bus.rsp0_valid || bus.rsp1_valid); i++)
      @(negedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d responses outstanding expected 0", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1);
  end

  initial begin
    int exp_grant[4];
    int g;
    int got_id;
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_grant = '{0, 0, 0, 0};
`else
    exp_grant = '{0, 1, 0, 1};
`endif
    bus.req0_a = 0; bus.req0_b = 0; bus.req0_op = 0;
    bus.req1_a = 0; bus.req1_b = 0; bus.req1_op = 0;
    do_reset();

    // Reset state
    @(negedge clk);
    check("rst_rsp0_valid", bus.rsp0_valid, 0);
    check("rst_rsp1_valid", bus.rsp1_valid, 0);
    check("rst_rsp_result", bus.rsp_result, 0);
    check("rst_rsp_zero", bus.rsp_zero, 0);
    check("rst_alu_in1", bus.alu_in1, 0);
    check("rst_alu_in2", bus.alu_in2, 0);
    check("rst_alu_ctrl", bus.alu_ctrl, 0);
    check("rst_req_ready", {bus.req0_ready, bus.req1_ready}, 0);
    @(posedge clk);
    #1;

    // Single requesters
    issue(0, 7, 5, 4'b0010, 12, 1'b0, 1'b1, 1'b1);
    drain();
    issue(1, 32'hF0, 32'h0F, 4'b0000, 0, 1'b1, 1'b1, 1'b1);
    drain();
    issue(1, 20, 8, 4'b0110, 12, 1'b0, 1'b1, 1'b0);
    drain();

    // Contention from a fresh reset
    do_reset();
    bus.req0_a = 3; bus.req0_b = 3; bus.req0_op = 4'b0110;
    bus.req1_a = 1; bus.req1_b = 2; bus.req1_op = 4'b0001;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    g = 0;
    for (int c = 0; c < 60 && g < 4; c++) begin
      @(negedge clk);
      if (bus.req0_ready && bus.req1_ready) begin
        n_cmp++;
        n_err++;
        $display("FAIL grant_exclusive: got both readies expected one");
      end
      if (bus.req0_ready || bus.req1_ready) begin
        got_id = bus.req1_ready ? 1 : 0;
        check("grant_order", got_id, exp_grant[g]);
        if (exp_grant[g] == 0) q.push_back('{id: 0, res: 32'd0, z: 1'b1});
        else                   q.push_back('{id: 1, res: 32'd3, z: 1'b0});
        g++;
      end
    end
    if (g < 4) begin
      n_cmp++;
      n_err++;
      $display("FAIL grant_timeout: got %0d grants expected 4", g);
    end
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    drain();

    // Stalled response: owner req1 holds ready low; non-owner ready is high
    bus.rsp1_ready = 1'b0;
    bus.rsp0_ready = 1'b1;
    issue(1, 10, 20, 4'b0010, 30, 1'b0, 1'b1, 1'b0);
    bus.req0_a = 1; bus.req0_b = 1; bus.req0_op = 4'b0010;
    bus.req0_valid = 1'b1;
    @(negedge clk);
    check("exec_req0_ready", bus.req0_ready, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_rsp1_valid", bus.rsp1_valid, 1);
      check("stall_rsp0_valid", bus.rsp0_valid, 0);
      check("stall_req_ready", {bus.req0_ready, bus.req1_ready}, 0);
      check("stall_rsp_result", bus.rsp_result, 30);
      check("stall_alu_in1", bus.alu_in1, 10);
    end
    @(posedge clk);
    #1;
    bus.rsp1_ready = 1'b1;
    bus.req0_valid = 1'b0;
    drain();

    // Reset while in EXEC drops the operation
    issue(0, 4, 4, 4'b0010, 8, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_exec_rsp_valid", {bus.rsp0_valid, bus.rsp1_valid}, 0);
    end
    check("rst_exec_rsp_result", bus.rsp_result, 0);
    check("rst_exec_alu_in1", bus.alu_in1, 0);
    @(posedge clk);
    #1;
    issue(0, 9, 1, 4'b0010, 10, 1'b0, 1'b1, 1'b1);
    drain();

    // Divide by zero and unknown op are passed through
    issue(0, 100, 0, 4'b0101, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1);
    drain();
    issue(1, 5, 6, 4'b1111, 0, 1'b1, 1'b1, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width; SHALL match the shared ALU width.
REQ-002 Port clk, input, 1, the single clock; every register SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1, reset; it SHALL be synchronous and active-low.
REQ-004 Ports req0_valid/req1_valid, input, 1 each, the requester has an operation pending.
REQ-005 Ports req0_ready/req1_ready, output, 1 each, the request is accepted this cycle.
REQ-006 Ports req0_a, req0_b / req1_a, req1_b, input, DATA_W each, operands.
REQ-007 Ports req0_op/req1_op, input, 4 each, ALU control code, passed through unmodified.
REQ-008 Ports rsp0_valid/rsp1_valid, output, 1 each, a result is held for that requester.
REQ-009 Ports rsp0_ready/rsp1_ready, input, 1 each, the requester consumes the result.
REQ-010 Ports rsp_result, output, DATA_W, and rsp_zero, output, 1: the held result and zero flag, shared by both requesters.
REQ-011 Ports alu_in1, alu_in2, output, DATA_W, and alu_ctrl, output, 4: drive the shared ALU.
REQ-012 Ports alu_result, input, DATA_W, and alu_zero, input, 1: taken from the shared ALU, which is purely combinational.

Function
REQ-013 FSM states SHALL be IDLE, EXEC and RESP.
REQ-014 In IDLE, reqN_ready SHALL be 1 only for the granted requester, and only when its reqN_valid is 1; all other ready signals SHALL be 0.
REQ-015 In EXEC and RESP, both req0_ready and req1_ready SHALL be 0.
REQ-016 A handshake (valid & ready) in IDLE SHALL register the operands and op into alu_in1/alu_in2/alu_ctrl, record the owner, and move to EXEC.
REQ-017 In EXEC, alu_result and alu_zero SHALL be captured into rsp_result/rsp_zero, the owner's rspN_valid SHALL be set, and the FSM SHALL move to RESP.
REQ-018 In RESP, the FSM SHALL stay until the owner's rspN_ready is 1; then rspN_valid SHALL clear and the FSM SHALL return to IDLE in the same edge.
REQ-019 Latency: a handshake in cycle T SHALL give rspN_valid=1 from cycle T+2; minimum issue interval is 3 cycles.
REQ-020 rsp_result, rsp_zero and alu_* SHALL remain stable while in RESP.
REQ-021 The non-owner's rsp valid SHALL stay 0 at all times, and its rsp ready SHALL be ignored.
REQ-022 Arbitration: with exactly one valid requester, that requester SHALL be granted.
REQ-023 With both requesters valid, the requester not granted last SHALL be granted (round-robin); the last-grant pointer SHALL update only on a handshake.
REQ-024 Op codes unknown to the ALU, and divide by zero, SHALL be passed through; the arbiter SHALL return whatever the ALU produces and add no checking.
REQ-025 Deasserting reqN_valid without a handshake SHALL be allowed and SHALL have no effect.

Reset
REQ-026 While rst_n=0 at a clock edge, the FSM SHALL go to IDLE and both rsp valid outputs SHALL be 0.
REQ-027 Reset SHALL clear rsp_result, alu_in1, alu_in2 and alu_ctrl to 0; rsp_zero SHALL reset to 0.
REQ-028 Reset SHALL set the last-grant pointer to requester 1, so that requester 0 wins the first contention.
REQ-029 Reset during EXEC or RESP SHALL drop the in-flight operation; no response SHALL ever be issued for it.

Configuration
REQ-030 Macro ALU_ARB_FIXED_PRIO_EN: when defined, requester 0 SHALL always win contention and the pointer SHALL be absent; when undefined, arbitration SHALL be round-robin per REQ-023.

Verification
REQ-031 Scenario: req0 alone, a=7, b=5, op=0010 -> req0_ready in cycle T, rsp0_valid at T+2, rsp_result=12, rsp_zero=0.
REQ-032 Scenario: both requesters valid continuously after reset (req0 op=0110, 3-3; req1 op=0001, 1|2), rsp ready tied to 1 -> grants alternate 0,1,0,1; results 0 with zero=1, then 3 with zero=0. With ALU_ARB_FIXED_PRIO_EN -> only req0 is granted.
REQ-033 Scenario: rsp1_ready held at 0 for 5 cycles -> the FSM stays in RESP, req ready outputs stay 0, and rsp_result stays stable until rsp1_ready rises.
REQ-034 Scenario: rst_n pulsed low in EXEC -> rsp0_valid and rsp1_valid stay 0 and the next operation completes normally.
REQ-035 Scenario: op=0101 with b=0, and op=1111 -> the ALU's outputs are returned unchanged (1111 gives result 0, zero=1); no hang.
